// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: table entry layout and FSM state encoding.
package i2c_pkg;

    localparam int I2C_SEQ_ENTRY_W = 16;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } i2c_seq_entry_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4,
        S_FINISH    = 3'd5
    } i2c_seq_state_e;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Host-side table/run/status signals plus the single-byte I2C master handshake.
// Handshake: m_start is held with stable m_addr/m_rw/m_data_in until m_busy=1 is seen;
// the transaction completes on the following m_busy 1->0 edge.
interface i2c_cmd_sequencer_if
    import i2c_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                       cfg_we;
    logic [IW-1:0]              cfg_waddr;
    logic [I2C_SEQ_ENTRY_W-1:0] cfg_wdata;
    logic                       run;
    logic [CW-1:0]              count;
    logic                       seq_busy;
    logic                       seq_done;
    logic                       seq_err;
    logic [IW-1:0]              cur_idx;
    logic [7:0]                 rd_data;
    logic                       rd_valid;
    logic                       m_start;
    logic [6:0]                 m_addr;
    logic                       m_rw;
    logic [7:0]                 m_data_in;
    logic [7:0]                 m_data_out;
    logic                       m_busy;
    logic                       m_done;

    // Environment view: the host plus the I2C master the sequencer drives.
    modport master (
        output cfg_we, cfg_waddr, cfg_wdata, run, count,
        output m_data_out, m_busy, m_done,
        input  seq_busy, seq_done, seq_err, cur_idx, rd_data, rd_valid,
        input  m_start, m_addr, m_rw, m_data_in
    );

    modport slave (
        input  cfg_we, cfg_waddr, cfg_wdata, run, count,
        input  m_data_out, m_busy, m_done,
        output seq_busy, seq_done, seq_err, cur_idx, rd_data, rd_valid,
        output m_start, m_addr, m_rw, m_data_in
    );

endinterface

// File: rtl/i2c_seq_table.sv
// DEPTH-entry command table: one synchronous write port, one asynchronous read port, no reset.
module i2c_seq_table
    import i2c_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we_i,
    input  logic [IW-1:0]  waddr_i,
    input  i2c_seq_entry_t wdata_i,
    input  logic [IW-1:0]  raddr_i,
    output i2c_seq_entry_t rdata_o
);

    i2c_seq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Replays a table of single-byte I2C commands through the master, with an idle gap after each.
// Optional transaction timeout/abort is built when I2C_SEQ_TIMEOUT_EN is defined.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = 270,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_cmd_sequencer_if.slave seq_if,
    output i2c_seq_state_e     state_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    i2c_seq_state_e state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]  gap_q, gap_d;
    i2c_seq_entry_t ent_q, ent_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           err_q, err_d;

    i2c_seq_entry_t tbl_rdata;
    logic           tbl_we;
    logic           timeout;
    logic [CW-1:0]  count_clamped;
    logic           unused_m_done;

    assign unused_m_done = seq_if.m_done;

    // The table is frozen while a sequence runs so replayed entries cannot change underneath it.
    assign tbl_we = seq_if.cfg_we && (state_q == S_IDLE);

    i2c_seq_table #(.DEPTH(DEPTH)) u_table (
        .clk     (clk),
        .we_i    (tbl_we),
        .waddr_i (seq_if.cfg_waddr),
        .wdata_i (seq_if.cfg_wdata),
        .raddr_i (idx_q),
        .rdata_o (tbl_rdata)
    );

    assign count_clamped = (seq_if.count > CW'(DEPTH)) ? CW'(DEPTH) : seq_if.count;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q;
    logic          waiting;

    assign waiting = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
    assign timeout = waiting && (to_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q <= '0;
        end else if (waiting) begin
            to_q <= to_q + TW'(1);
        end else begin
            to_q <= '0;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        ent_d      = ent_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (seq_if.run) begin
                    err_d = 1'b0;
                    if (count_clamped == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        cnt_d   = count_clamped;
                        idx_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                ent_d   = tbl_rdata;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else if (seq_if.m_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // busy was high on entry, so seeing it low here is the falling edge
                if (!seq_if.m_busy) begin
                    if (ent_q.rw) begin
                        rd_data_d  = seq_if.m_data_out;
                        rd_valid_d = 1'b1;
                    end
                    gap_d   = '0;
                    state_d = S_GAP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (CW'(idx_q) == cnt_q - CW'(1)) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_ISSUE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            ent_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            ent_q      <= ent_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign seq_if.seq_busy  = (state_q != S_IDLE);
    assign seq_if.seq_done  = (state_q == S_FINISH);
    assign seq_if.seq_err   = err_q;
    assign seq_if.cur_idx   = idx_q;
    assign seq_if.rd_data   = rd_data_q;
    assign seq_if.rd_valid  = rd_valid_q;
    assign seq_if.m_start   = (state_q == S_WAIT_BUSY);
    assign seq_if.m_addr    = ent_q.addr;
    assign seq_if.m_rw      = ent_q.rw;
    assign seq_if.m_data_in = ent_q.data;
    assign state_o          = state_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: behavioural I2C master, table model and scoreboard.
module tb_i2c_cmd_sequencer;
    import i2c_pkg::*;

    localparam int DEPTH      = 16;
    localparam int GAP        = 8;
    localparam int TMO        = 64;
    localparam int RUN_BUDGET = 6000;

    typedef struct {
        string       name;
        logic [4:0]  count;
        logic        wr;
        logic [3:0]  wr_idx;
        logic [15:0] wr_data;
        bit          disturb;
        int          exp_ntx;
        int          exp_start_k;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    i2c_seq_state_e state;

    i2c_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

    i2c_cmd_sequencer #(
        .DEPTH          (DEPTH),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seq_if  (bus),
        .state_o (state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    bit          mdl_mute = 1'b0;
    logic [15:0] tbl_m [DEPTH];
    logic [15:0] exp_q [$];
    logic [7:0]  rd_exp_q [$];
    vec_t        vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] ret_fn(input logic [6:0] a, input logic [7:0] d);
        return {1'b0, a} ^ d ^ 8'hED;
    endfunction

    // Master model: busy rises 3-20 cycles after start, falls 200 cycles later.
    initial begin
        int mdl_phase;
        int mdl_cnt;
        int cyc;
        int last_fall;
        logic [15:0] got;
        bus.m_busy = 1'b0; bus.m_done = 1'b0; bus.m_data_out = '0;
        mdl_phase = 0; mdl_cnt = 0; cyc = 0; last_fall = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                bus.m_busy = 1'b0;
                mdl_phase  = 0;
                last_fall  = -1;
            end else begin
                case (mdl_phase)
                    0: if (bus.m_start && !mdl_mute) begin
                        if (last_fall >= 0 && bus.cur_idx != '0)
                            check("gap_busy_fall_to_next_start", cyc - last_fall, GAP + 2);
                        last_fall = -1;
                        mdl_cnt   = $urandom_range(3, 20);
                        mdl_phase = 1;
                        bus.m_done = 1'b0;
                    end
                    1: begin
                        mdl_cnt--;
                        if (mdl_cnt == 0) begin
                            got = {bus.m_rw, bus.m_addr, bus.m_data_in};
                            check("start_held_until_busy", bus.m_start, 1'b1);
                            n_txn++;
                            if (exp_q.size() == 0) begin
                                n_checks++; n_errors++;
                                $display("FAIL txn_unexpected: got %0h expected none", got);
                            end else begin
                                check("txn_fields", got, exp_q.pop_front());
                            end
                            bus.m_data_out = ret_fn(bus.m_addr, bus.m_data_in);
                            bus.m_busy = 1'b1;
                            mdl_cnt    = 200;
                            mdl_phase  = 2;
                        end
                    end
                    2: begin
                        mdl_cnt--;
                        if (mdl_cnt == 0) begin
                            bus.m_busy = 1'b0;
                            bus.m_done = 1'b1;
                            last_fall  = cyc;
                            mdl_phase  = 0;
                        end
                    end
                    default: mdl_phase = 0;
                endcase
            end
        end
    end

    // Read scoreboard: every rd_valid pulse must match the next expected read byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rd_valid === 1'b1) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL rd_valid_unexpected: got %0h expected none", bus.rd_data);
            end else begin
                check("rd_data", bus.rd_data, rd_exp_q.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {bus.seq_busy, bus.seq_done, bus.seq_err, bus.cur_idx,
                               bus.rd_data, bus.rd_valid, bus.m_start}, '0);
        check({name, "_bus"}, {bus.m_addr, bus.m_rw, bus.m_data_in}, '0);
        check({name, "_state"}, state, S_IDLE);
    endtask

    task automatic write_entry(input logic [3:0] idx, input logic [15:0] data);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_waddr = idx; bus.cfg_wdata = data;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        tbl_m[idx] = data;
    endtask

    task automatic run_seq(input string name, input logic [4:0] cnt, input logic wr,
                           input logic [3:0] wr_idx, input logic [15:0] wr_data,
                           input bit disturb, input int exp_ntx, input int exp_start_k);
        int k, done_k, first_start, txn0, idx_at_done;
        if (wr) tbl_m[wr_idx] = wr_data;
        for (int i = 0; i < exp_ntx; i++) begin
            exp_q.push_back(tbl_m[i]);
            if (tbl_m[i][15]) rd_exp_q.push_back(ret_fn(tbl_m[i][14:8], tbl_m[i][7:0]));
        end
        txn0 = n_txn;
        @(negedge clk);
        bus.run = 1'b1; bus.count = cnt;
        bus.cfg_we = wr; bus.cfg_waddr = wr_idx; bus.cfg_wdata = wr_data;
        @(negedge clk);
        bus.run = 1'b0; bus.count = '0; bus.cfg_we = 1'b0;
        k = 1; done_k = -1; first_start = -1; idx_at_done = 0;
        while (done_k < 0 && k < RUN_BUDGET) begin
            if (bus.m_start && first_start < 0) first_start = k;
            if (bus.seq_done) begin
                done_k = k;
                idx_at_done = int'(bus.cur_idx);
            end
            if (disturb && k == 60) begin
                bus.run = 1'b1; bus.count = 5'd1;
                bus.cfg_we = 1'b1; bus.cfg_waddr = '0; bus.cfg_wdata = 16'hFFFF;
            end
            if (disturb && k == 61) begin
                bus.run = 1'b0; bus.count = '0; bus.cfg_we = 1'b0;
            end
            if (done_k < 0) begin
                @(negedge clk);
                k++;
            end
        end
        check({name, "_done_seen"}, done_k >= 0, 1'b1);
        if (exp_ntx == 0) check({name, "_done_latency"}, done_k, 1);
        else check({name, "_cur_idx_at_done"}, idx_at_done, exp_ntx - 1);
        check({name, "_first_start_cycle"}, (first_start < 0) ? 0 : first_start, exp_start_k);
        check({name, "_seq_err"}, bus.seq_err, 1'b0);
        check({name, "_txn_count"}, n_txn - txn0, exp_ntx);
        check({name, "_pending_txn"}, exp_q.size(), 0);
        check({name, "_pending_rd"}, rd_exp_q.size(), 0);
        exp_q.delete();
        rd_exp_q.delete();
        @(negedge clk);
        check({name, "_done_width"}, bus.seq_done, 1'b0);
        check({name, "_busy_after"}, bus.seq_busy, 1'b0);
    endtask

    initial begin
        int k, done_k, cnt, n;
        logic err_at_done;
        rst_n = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_waddr = '0; bus.cfg_wdata = '0;
        bus.run = 1'b0; bus.count = '0;

        vecs[0] = '{"three_writes",  5'd3,  1'b0, 4'd0, 16'h0000, 1'b0, 3,  2};
        vecs[1] = '{"count_zero",    5'd0,  1'b0, 4'd0, 16'h0000, 1'b0, 0,  0};
        vecs[2] = '{"read_with_cfg", 5'd1,  1'b1, 4'd0, 16'hC800, 1'b0, 1,  2};
        vecs[3] = '{"disturbed",     5'd2,  1'b0, 4'd0, 16'h0000, 1'b1, 2,  2};
        vecs[4] = '{"after_disturb", 5'd1,  1'b0, 4'd0, 16'h0000, 1'b0, 1,  2};
        vecs[5] = '{"clamp_20",      5'd20, 1'b0, 4'd0, 16'h0000, 1'b0, 16, 2};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        write_entry(4'd0, {1'b0, 7'h3C, 8'h11});
        write_entry(4'd1, {1'b0, 7'h3C, 8'h22});
        write_entry(4'd2, {1'b0, 7'h50, 8'h33});
        for (int i = 3; i < DEPTH; i++) write_entry(4'(i), 16'($urandom));

        for (int v = 0; v < 6; v++) begin
            run_seq(vecs[v].name, vecs[v].count, vecs[v].wr, vecs[v].wr_idx, vecs[v].wr_data,
                    vecs[v].disturb, vecs[v].exp_ntx, vecs[v].exp_start_k);
            if (v == 2) check("read_byte_a5", bus.rd_data, 8'hA5);
        end

        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 4; w++) write_entry(4'($urandom_range(0, DEPTH - 1)), 16'($urandom));
            cnt = $urandom_range(0, 20);
            n = (cnt > DEPTH) ? DEPTH : cnt;
            run_seq("random", 5'(cnt), 1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)),
                    16'($urandom), 1'b0, n, (n > 0) ? 2 : 0);
        end

        // Master never answers: abort with the timeout, or hang until reset.
        mdl_mute = 1'b1;
        @(negedge clk);
        bus.run = 1'b1; bus.count = 5'd1;
        @(negedge clk);
        bus.run = 1'b0; bus.count = '0;
        k = 1; done_k = -1; err_at_done = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        while (done_k < 0 && k < 200) begin
            if (bus.seq_done) begin
                done_k = k;
                err_at_done = bus.seq_err;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check("timeout_done_cycle", done_k, 66);
        check("timeout_err", err_at_done, 1'b1);
        @(negedge clk);
        check("timeout_err_sticky", bus.seq_err, 1'b1);
        check("timeout_start_dropped", bus.m_start, 1'b0);
`else
        repeat (300) @(negedge clk);
        check("hang_busy", bus.seq_busy, 1'b1);
        check("hang_start_held", bus.m_start, 1'b1);
        check("hang_err", bus.seq_err, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("hang_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        mdl_mute = 1'b0;
        run_seq("recover", 5'd2, 1'b0, 4'd0, 16'h0000, 1'b0, 2, 2);

        // Reset in the middle of a transaction, then replay from entry 0.
        exp_q.push_back(tbl_m[0]);
        @(negedge clk);
        bus.run = 1'b1; bus.count = 5'd3;
        @(negedge clk);
        bus.run = 1'b0; bus.count = '0;
        k = 0;
        while (state != S_WAIT_DONE && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reached_wait_done", state, S_WAIT_DONE);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("wait_done_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        rd_exp_q.delete();
        run_seq("after_reset", 5'd2, 1'b0, 4'd0, 16'h0000, 1'b0, 2, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
